// File: rtl/btn_evt_pkg.sv
// Shared types and helpers for the button event decoder.
// Latency: n/a (types and elaboration-time functions only).
// Backpressure: n/a.
package btn_evt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_HELD,
    ST_WAIT2,
    ST_PRESSED2
  } btn_state_t;

  typedef enum logic [1:0] {
    EVT_REPEAT = 2'd0,
    EVT_SHORT  = 2'd1,
    EVT_LONG   = 2'd2,
    EVT_DOUBLE = 2'd3
  } btn_evt_t;

  // Milliseconds to clock cycles for a clock given in MHz.
  function automatic logic [63:0] ms_to_cyc(input int unsigned ms, input int unsigned freq_mhz);
    return 64'(ms) * 64'(freq_mhz) * 64'd1000;
  endfunction

  // A limit is usable when it is non-zero and representable in n bits.
  function automatic bit cyc_fits(input logic [63:0] cyc, input int unsigned n);
    if (cyc == 64'd0) return 1'b0;
    if (n >= 64) return 1'b1;
    return cyc <= ((64'd1 << n) - 64'd1);
  endfunction

endpackage

// File: rtl/btn_evt_timer.sv
// Saturating cycle counter with synchronous clear and an equality hit against a runtime limit.
// Latency: hit is combinational from the counter register; count updates one cycle after clear/en.
// Backpressure: none; en low freezes the count.
//
// Ports: clk, rst (sync, active-low), clear, en, limit[N-1:0], hit.
module btn_evt_timer #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  input  logic [N-1:0] limit,
  output logic         hit
);

  logic [N-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hit = (cnt == limit);

endmodule

// File: rtl/btn_event_decoder.sv
// Classifies debounced press/release pulses into SHORT / LONG / DOUBLE (and optional REPEAT) events.
// Latency: event registered one cycle after the deciding pulse or timeout cycle.
// Backpressure: valid/ready; an event raised while one is still pending is dropped and sets evt_overflow.
//
// Ports: clk, rst (sync, active-low), btn_press, btn_release (one-cycle pulses),
//        evt_valid/evt_code/evt_ready (event handshake), held (button down), evt_overflow (sticky).
// Build option: define BTN_REPEAT_EN to emit REPEAT events every REPEAT_MS while held after a LONG.
module btn_event_decoder
  import btn_evt_pkg::*;
#(
  parameter int unsigned FREQ      = 50,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned DOUBLE_MS = 300,
  parameter int unsigned REPEAT_MS = 200,
  parameter int unsigned N         = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_press,
  input  logic       btn_release,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  input  logic       evt_ready,
  output logic       held,
  output logic       evt_overflow
);

  localparam logic [63:0] LONG_CYC = ms_to_cyc(LONG_MS, FREQ);
  localparam logic [63:0] DBL_CYC  = ms_to_cyc(DOUBLE_MS, FREQ);
  localparam logic [63:0] REP_CYC  = ms_to_cyc(REPEAT_MS, FREQ);

  if (!cyc_fits(LONG_CYC, N) || !cyc_fits(DBL_CYC, N) || !cyc_fits(REP_CYC, N)) begin : g_limit_check
    $error("btn_event_decoder: a cycle limit is zero or does not fit in N bits");
  end

  // The counter starts at 0 on entry, so a timeout fires when it reads limit-1.
  localparam logic [N-1:0] LONG_LIM = N'(LONG_CYC - 64'd1);
  localparam logic [N-1:0] DBL_LIM  = N'(DBL_CYC - 64'd1);
`ifdef BTN_REPEAT_EN
  localparam logic [N-1:0] REP_LIM  = N'(REP_CYC - 64'd1);
`endif

  btn_state_t   state, state_nxt;
  logic         press_ev, rel_ev, quiet, both;
  logic [N-1:0] limit;
  logic         hit, tmr_clear, emit;
  btn_evt_t     emit_code;

  // A lone pulse is an event; both together cancel out and freeze everything.
  assign press_ev = btn_press && !btn_release;
  assign rel_ev   = btn_release && !btn_press;
  assign both     = btn_press && btn_release;
  // Timeouts only act in cycles with no pulse at all, even an ignored one.
  assign quiet    = !btn_press && !btn_release;

  btn_evt_timer #(.N(N)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (tmr_clear),
    .en    (!both),
    .limit (limit),
    .hit   (hit)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    emit_code = EVT_SHORT;
    tmr_clear = 1'b0;
    limit     = LONG_LIM;
    case (state)
      ST_IDLE: begin
        if (press_ev) state_nxt = ST_PRESSED;
      end
      ST_PRESSED: begin
        limit = LONG_LIM;
        if (rel_ev) begin
          state_nxt = ST_WAIT2;
        end else if (quiet && hit) begin
          emit      = 1'b1;
          emit_code = EVT_LONG;
          state_nxt = ST_HELD;
        end
      end
      ST_HELD: begin
        if (rel_ev) begin
          state_nxt = ST_IDLE;
        end
`ifdef BTN_REPEAT_EN
        else begin
          limit = REP_LIM;
          if (quiet && hit) begin
            emit      = 1'b1;
            emit_code = EVT_REPEAT;
            tmr_clear = 1'b1;
          end
        end
`endif
      end
      ST_WAIT2: begin
        limit = DBL_LIM;
        if (press_ev) begin
          emit      = 1'b1;
          emit_code = EVT_DOUBLE;
          state_nxt = ST_PRESSED2;
        end else if (quiet && hit) begin
          emit      = 1'b1;
          emit_code = EVT_SHORT;
          state_nxt = ST_IDLE;
        end
      end
      ST_PRESSED2: begin
        if (rel_ev) state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    if (state_nxt != state) tmr_clear = 1'b1;
  end

  // Event slot: loads when empty or being drained this cycle; otherwise the new event is lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      held         <= 1'b0;
      evt_valid    <= 1'b0;
      evt_code     <= 2'd0;
      evt_overflow <= 1'b0;
    end else begin
      held <= (state_nxt == ST_PRESSED) || (state_nxt == ST_HELD) || (state_nxt == ST_PRESSED2);
      if (emit && (!evt_valid || evt_ready)) begin
        evt_valid <= 1'b1;
        evt_code  <= emit_code;
      end else begin
        if (evt_valid && evt_ready) evt_valid <= 1'b0;
        if (emit) evt_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_btn_event_decoder.sv
// Self-checking bench for btn_event_decoder: table of gesture scenarios plus hand-written corner sequences.
// Latency: n/a.
// Backpressure: evt_ready is held high except in the overflow and reset sequences.
module tb_btn_event_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_press = 1'b0;
  logic       btn_release = 1'b0;
  logic       evt_ready = 1'b1;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       held;
  logic       evt_overflow;

  always #5 clk = ~clk;

  btn_event_decoder #(
    .FREQ(1), .LONG_MS(4), .DOUBLE_MS(2), .REPEAT_MS(1), .N(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_press    (btn_press),
    .btn_release  (btn_release),
    .evt_valid    (evt_valid),
    .evt_code     (evt_code),
    .evt_ready    (evt_ready),
    .held         (held),
    .evt_overflow (evt_overflow)
  );

`ifdef BTN_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  typedef struct {
    string name;
    int p1, p2, r1, r2;     // pulse cycles, -1 = none
    int end_cyc;
    int n_evt;
    int f_cyc, f_code;      // first accepted event, -1 = none
    int l_cyc, l_code;      // last accepted event
    int h_first, h_last;    // first/last cycle with held high, -1 = never
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ev_cyc[$];
  int ev_code[$];
  int n_valid;
  int held_first;
  int held_last;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
    end
  endtask

  // Record the outputs of the current cycle, drive this cycle's inputs, advance one clock.
  task automatic step(input bit p, input bit r);
    if (evt_valid === 1'b1) n_valid++;
    if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
      ev_cyc.push_back(cyc);
      ev_code.push_back(int'(evt_code));
    end
    if (held === 1'b1) begin
      if (held_first < 0) held_first = cyc;
      held_last = cyc;
    end
    btn_press   = p;
    btn_release = r;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    btn_press   = 1'b0;
    btn_release = 1'b0;
    rst         = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
    ev_cyc.delete();
    ev_code.delete();
    n_valid    = 0;
    held_first = -1;
    held_last  = -1;
  endtask

  initial begin
    vecs[0]  = '{"short",        10,   -1,  500,   -1, 2700, 1, 2501, 1, 2501, 1, 11,  500};
    vecs[1]  = '{"long",         10,   -1, 9000,   -1, 9100, REP ? 5 : 1, 4011, 2,
                 REP ? 8011 : 4011, REP ? 0 : 2, 11, 9000};
    vecs[2]  = '{"double",       10, 1500,  300, 6500, 6600, 1, 1501, 3, 1501, 3, 11, 6500};
    vecs[3]  = '{"quick",        10,   -1,   20,   -1, 2500, 1, 2021, 1, 2021, 1, 11,   20};
    vecs[4]  = '{"rel_long_edge",10,   -1, 4010,   -1, 6500, 1, 6011, 1, 6011, 1, 11, 4010};
    vecs[5]  = '{"rel_after_lng",10,   -1, 4011,   -1, 4500, 1, 4011, 2, 4011, 2, 11, 4011};
    vecs[6]  = '{"p2_dbl_edge",  10, 2100,  100, 2200, 4700, 1, 2101, 3, 2101, 3, 11, 2200};
    vecs[7]  = '{"p2_after_dbl", 10, 2101,  100, 2200, 4700, 2, 2101, 1, 4201, 1, 11, 2200};
    vecs[8]  = '{"rel_dbl_edge", 10,   -1,  100, 2100, 4700, 0,   -1, -1,  -1, -1, 11,  100};
    vecs[9]  = '{"both_idle",    10,   -1,   10,   -1, 2500, 0,   -1, -1,  -1, -1, -1,   -1};
    vecs[10] = '{"both_pressed", 10,  100,  100, 6000, 6500, REP ? 2 : 1, 4012, 2,
                 REP ? 5012 : 4012, REP ? 0 : 2, 11, 6000};

    // Reset state.
    do_reset();
    check("reset.evt_valid", int'(evt_valid), 0);
    check("reset.evt_code", int'(evt_code), 0);
    check("reset.held", int'(held), 0);
    check("reset.evt_overflow", int'(evt_overflow), 0);

    // Gesture table.
    for (int i = 0; i < NV; i++) begin
      do_reset();
      evt_ready = 1'b1;
      while (cyc <= vecs[i].end_cyc)
        step((cyc == vecs[i].p1) || (cyc == vecs[i].p2), (cyc == vecs[i].r1) || (cyc == vecs[i].r2));
      check({vecs[i].name, ".count"}, ev_cyc.size(), vecs[i].n_evt);
      check({vecs[i].name, ".valid_cycles"}, n_valid, vecs[i].n_evt);
      check({vecs[i].name, ".first_cyc"}, (ev_cyc.size() > 0) ? ev_cyc[0] : -1, vecs[i].f_cyc);
      check({vecs[i].name, ".first_code"}, (ev_code.size() > 0) ? ev_code[0] : -1, vecs[i].f_code);
      check({vecs[i].name, ".last_cyc"}, (ev_cyc.size() > 0) ? ev_cyc[ev_cyc.size()-1] : -1, vecs[i].l_cyc);
      check({vecs[i].name, ".last_code"}, (ev_code.size() > 0) ? ev_code[ev_code.size()-1] : -1, vecs[i].l_code);
      check({vecs[i].name, ".held_first"}, held_first, vecs[i].h_first);
      check({vecs[i].name, ".held_last"}, held_last, vecs[i].h_last);
      check({vecs[i].name, ".overflow"}, int'(evt_overflow), 0);
    end

    // Overflow: SHORT pending with no consumer, then a LONG is dropped.
    do_reset();
    evt_ready = 1'b0;
    wait_until(10);   step(1'b1, 1'b0);
    wait_until(20);   step(1'b0, 1'b1);
    wait_until(2020);
    check("ovf.valid_before_short", int'(evt_valid), 0);
    step(1'b0, 1'b0);
    check("ovf.short_valid", int'(evt_valid), 1);
    check("ovf.short_code", int'(evt_code), 1);
    wait_until(2100); step(1'b1, 1'b0);
    wait_until(6100);
    check("ovf.flag_before_long", int'(evt_overflow), 0);
    step(1'b0, 1'b0);
    check("ovf.flag_after_long", int'(evt_overflow), 1);
    check("ovf.held_valid", int'(evt_valid), 1);
    check("ovf.held_code", int'(evt_code), 1);
    wait_until(6300); step(1'b0, 1'b1);
    wait_until(6400);
    evt_ready = 1'b1;
    check("ovf.valid_at_handshake", int'(evt_valid), 1);
    step(1'b0, 1'b0);
    check("ovf.valid_after_handshake", int'(evt_valid), 0);
    check("ovf.flag_sticky", int'(evt_overflow), 1);
    check("ovf.handshakes", ev_cyc.size(), 1);
    check("ovf.accepted_code", (ev_code.size() > 0) ? ev_code[0] : -1, 1);

    // Reset mid-hold with an event still pending.
    do_reset();
    evt_ready = 1'b0;
    wait_until(10);   step(1'b1, 1'b0);
    wait_until(20);   step(1'b0, 1'b1);
    wait_until(2100); step(1'b1, 1'b0);
    wait_until(4100);
    check("rst.held_before", int'(held), 1);
    check("rst.pending_before", int'(evt_valid), 1);
    rst = 1'b0;
    step(1'b0, 1'b0);
    rst = 1'b1;
    check("rst.evt_valid", int'(evt_valid), 0);
    check("rst.evt_code", int'(evt_code), 0);
    check("rst.held", int'(held), 0);
    check("rst.evt_overflow", int'(evt_overflow), 0);
    evt_ready = 1'b1;
    n_valid = 0;
    wait_until(6600);
    check("rst.no_long_after", n_valid, 0);
    check("rst.held_stays_low", int'(held), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
